// File: rtl/tb_dina_map_if.sv
// RSA-result / TB BRAM port-A write bundle between the controller side (master) and the dina mapper (slave).
interface tb_dina_map_if #(
    parameter int unsigned X              = 4,
    parameter int unsigned L              = 4,
    parameter int unsigned RSA_DW         = 32,
    parameter int unsigned SEQ_CNT_DW     = 5,
    parameter int unsigned TB_DINA_SEL_DW = 5
);
    logic [TB_DINA_SEL_DW-1:0] TB_dina_sel;
    logic                      l_k_0;
    logic [SEQ_CNT_DW-1:0]     seq_cnt_in;
    logic [X*RSA_DW-1:0]       C_TB_dina;
    logic                      C_TB_vld;
    logic [L*RSA_DW-1:0]       TB_dina;
    logic [L-1:0]              TB_wea;
    logic                      TB_wr_row;
    logic                      trans_done;

    modport master (
        output TB_dina_sel, l_k_0, seq_cnt_in, C_TB_dina, C_TB_vld,
        input  TB_dina, TB_wea, TB_wr_row, trans_done
    );

    modport slave (
        input  TB_dina_sel, l_k_0, seq_cnt_in, C_TB_dina, C_TB_vld,
        output TB_dina, TB_wea, TB_wr_row, trans_done
    );
endinterface

// File: rtl/tb_dina_map.sv
// Maps the RSA result vector onto TB BRAM port-A write data and lane enables;
// direct modes permute lanes, transpose mode deskews a 2x2 block and writes it transposed.
module tb_dina_map #(
    parameter int unsigned X              = 4,
    parameter int unsigned L              = 4,
    parameter int unsigned RSA_DW         = 32,
    parameter int unsigned SEQ_CNT_DW     = 5,
    parameter int unsigned TB_DINA_SEL_DW = 5,
    parameter int unsigned TRANS_SEQ0     = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    tb_dina_map_if.slave  bus
);
    localparam int unsigned DINA_W = L * RSA_DW;

    localparam logic [2:0] MODE_DIRECT = 3'b001;
    localparam logic [2:0] MODE_TRANS  = 3'b101;
    localparam logic [1:0] DIR_POS     = 2'b01;
    localparam logic [1:0] DIR_NEG     = 2'b10;
    localparam logic [1:0] DIR_NEW     = 2'b11;

    localparam logic [L-1:0] WEA_ALL = '1;
    localparam logic [L-1:0] WEA_LO  = L'(4'b0011);
    localparam logic [L-1:0] WEA_HI  = L'(4'b1100);

    typedef enum logic [1:0] {T_IDLE, T_S1, T_S2, T_S3} t_state_e;

    t_state_e          state_q, state_d;
    logic [DINA_W-1:0] dina_q, dina_d;
    logic [L-1:0]      wea_q, wea_d;
    logic              wr_row_q, wr_row_d;
    logic              done_q, done_d;
    logic              lk_q, lk_d;
    logic [RSA_DW-1:0] a00_q, a00_d, a10_q, a10_d, a01_q, a01_d, a11_q, a11_d;

    logic [2:0]        mode;
    logic [1:0]        dir;
    logic [RSA_DW-1:0] c_lane [X];

    assign mode = bus.TB_dina_sel[TB_DINA_SEL_DW-1 -: 3];
    assign dir  = bus.TB_dina_sel[1:0];

    always_comb begin
        for (int i = 0; i < X; i++) c_lane[i] = bus.C_TB_dina[i*RSA_DW +: RSA_DW];
    end

    // Two words into lanes 0,1 (lower half) or lanes 2,3 (upper half); other lanes zero.
    function automatic logic [DINA_W-1:0] place_pair(input logic lo_half,
                                                     input logic [RSA_DW-1:0] w0,
                                                     input logic [RSA_DW-1:0] w1);
        logic [DINA_W-1:0] r;
        r = '0;
        if (lo_half) begin
            r[0*RSA_DW +: RSA_DW] = w0;
            r[1*RSA_DW +: RSA_DW] = w1;
        end else begin
            r[2*RSA_DW +: RSA_DW] = w0;
            r[3*RSA_DW +: RSA_DW] = w1;
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        dina_d   = '0;
        wea_d    = '0;
        wr_row_d = wr_row_q;
        done_d   = 1'b0;
        lk_d     = lk_q;
        a00_d    = a00_q;
        a10_d    = a10_q;
        a01_d    = a01_q;
        a11_d    = a11_q;

        unique case (mode)
            MODE_DIRECT: begin
                state_d = T_IDLE;
                unique case (dir)
                    DIR_POS: begin
                        for (int i = 0; i < L; i++) dina_d[i*RSA_DW +: RSA_DW] = c_lane[i];
                        wea_d = WEA_ALL;
                    end
                    DIR_NEG: begin
                        for (int i = 0; i < L; i++) dina_d[i*RSA_DW +: RSA_DW] = c_lane[X-1-i];
                        wea_d = WEA_ALL;
                    end
                    DIR_NEW: begin
                        dina_d = place_pair(bus.l_k_0, c_lane[0], c_lane[1]);
                        wea_d  = bus.l_k_0 ? WEA_LO : WEA_HI;
                    end
                    default: ;
                endcase
                // Data stays mapped on invalid cycles; only the enables drop.
                if (!bus.C_TB_vld) wea_d = '0;
            end
            MODE_TRANS: begin
                unique case (state_q)
                    T_IDLE: begin
                        if (bus.seq_cnt_in == SEQ_CNT_DW'(TRANS_SEQ0)) begin
                            a00_d   = c_lane[0];
                            lk_d    = bus.l_k_0;
                            state_d = T_S1;
                        end
                    end
                    T_S1: begin
                        a10_d   = c_lane[0];
                        a01_d   = c_lane[1];
                        state_d = T_S2;
                    end
                    T_S2: begin
                        a11_d    = c_lane[1];
                        dina_d   = place_pair(lk_q, a00_q, a10_q);
                        wea_d    = lk_q ? WEA_LO : WEA_HI;
                        wr_row_d = 1'b0;
                        state_d  = T_S3;
                    end
                    T_S3: begin
                        dina_d   = place_pair(lk_q, a01_q, a11_q);
                        wea_d    = lk_q ? WEA_LO : WEA_HI;
                        wr_row_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = T_IDLE;
                    end
                    default: state_d = T_IDLE;
                endcase
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q  <= T_IDLE;
            dina_q   <= '0;
            wea_q    <= '0;
            wr_row_q <= 1'b0;
            done_q   <= 1'b0;
            lk_q     <= 1'b0;
            a00_q    <= '0;
            a10_q    <= '0;
            a01_q    <= '0;
            a11_q    <= '0;
        end else begin
            state_q  <= state_d;
            dina_q   <= dina_d;
            wea_q    <= wea_d;
            wr_row_q <= wr_row_d;
            done_q   <= done_d;
            lk_q     <= lk_d;
            a00_q    <= a00_d;
            a10_q    <= a10_d;
            a01_q    <= a01_d;
            a11_q    <= a11_d;
        end
    end

    assign bus.TB_dina    = dina_q;
    assign bus.TB_wea     = wea_q;
    assign bus.TB_wr_row  = wr_row_q;
    assign bus.trans_done = done_q;
endmodule
